// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback sequencer that feeds an 8-bit ALU from an 8x8 register file
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_instruction          OP[31:24] DEST[23:16] SRC1[15:8] SRC2/IMM[7:0]
//   i_instr_valid          instruction valid; o_instr_ready accepts it
//   o_alu_data1/2          ALU operands, held from accept until the next legal accept
//   o_alu_select           ALU function (000 fwd, 001 add, 010 and, 011 or)
//   i_alu_result           ALU output, sampled LAT_FWD/LAT_ADD edges after accept
//   o_wb_valid/addr/data   one-cycle writeback pulse with the register written
//   o_illegal              one-cycle pulse when an unsupported opcode is accepted
//   i_dbg_addr/o_dbg_data  combinational register file read
// Option: define ALU_ISSUE_SUB_EN to accept opcode 0x03 as sub (negated SRC2 with ALU add).
module alu_issue_ctrl #(
    parameter int LAT_FWD = 1,
    parameter int LAT_ADD = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instruction,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    output logic [7:0]  o_alu_data1,
    output logic [7:0]  o_alu_data2,
    output logic [2:0]  o_alu_select,
    input  logic [7:0]  i_alu_result,
    output logic        o_wb_valid,
    output logic [2:0]  o_wb_addr,
    output logic [7:0]  o_wb_data,
    output logic        o_illegal,
    input  logic [2:0]  i_dbg_addr,
    output logic [7:0]  o_dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t     r_state;
    logic [7:0] r_regs [8];
    logic       r_ready, r_wb_valid, r_illegal;
    logic [7:0] r_d1, r_d2, r_wb_data;
    logic [2:0] r_sel, r_cnt, r_dest, r_wb_addr;
    logic [7:0] w_op, w_imm, w_rs1, w_rs2, w_d2;
    logic [2:0] w_dest, w_src1, w_src2, w_sel, w_lat;
    logic       w_legal, w_accept, w_unused;
    assign w_op     = i_instruction[31:24];
    assign w_dest   = i_instruction[18:16];
    assign w_src1   = i_instruction[10:8];
    assign w_src2   = i_instruction[2:0];
    assign w_imm    = i_instruction[7:0];
    assign w_unused = ^{i_instruction[23:19], i_instruction[15:11]};
    assign w_rs1    = r_regs[w_src1];
    assign w_rs2    = r_regs[w_src2];
`ifdef ALU_ISSUE_SUB_EN
    assign w_legal  = w_op <= 8'h05;
    assign w_d2     = (w_op == 8'h00) ? w_imm : (w_op == 8'h03) ? 8'h00 - w_rs2 : w_rs2;
`else
    assign w_legal  = (w_op <= 8'h05) && (w_op != 8'h03);
    assign w_d2     = (w_op == 8'h00) ? w_imm : w_rs2;
`endif
    assign w_sel    = (w_op == 8'h04) ? 3'b010 :
                      (w_op == 8'h05) ? 3'b011 :
                      (w_op == 8'h02 || w_op == 8'h03) ? 3'b001 : 3'b000;
    assign w_lat    = (w_sel == 3'b001) ? 3'(LAT_ADD) : 3'(LAT_FWD);
    assign w_accept = i_instr_valid && r_ready;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_dest     <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Illegal opcodes leave the ALU ports alone and keep accepting.
                    r_ready   <= !(w_accept && w_legal);
                    r_illegal <= w_accept && !w_legal;
                    if (w_accept && w_legal) begin
                        r_d1    <= w_rs1;
                        r_d2    <= w_d2;
                        r_sel   <= w_sel;
                        r_cnt   <= w_lat;
                        r_dest  <= w_dest;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == 3'd1) begin
                        r_regs[r_dest] <= i_alu_result;
                        r_wb_addr      <= r_dest;
                        r_wb_data      <= i_alu_result;
                        r_wb_valid     <= 1'b1;
                        r_state        <= WB;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                WB: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_instr_ready = r_ready;
    assign o_alu_data1   = r_d1;
    assign o_alu_data2   = r_d2;
    assign o_alu_select  = r_sel;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_addr     = r_wb_addr;
    assign o_wb_data     = r_wb_data;
    assign o_illegal     = r_illegal;
    assign o_dbg_data    = r_regs[i_dbg_addr];
endmodule
